// File: rtl/adder_acc_pkg.sv
// adder_acc_pkg
//   Shared types and defaults for the adder result accumulator.
//   - state_t      : accumulator FSM state (IDLE, ACCUM, HOLD), 2 bits.
//   - DEF_*        : default widths for the accumulator parameters.
//   - max1()       : maps a burst length of 0 to 1.
package adder_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_IN_W   = 8;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_ACC_W  = 12;
  localparam int DEF_DROP_W = 8;

  // A programmed length of 0 still means "one beat".
  function automatic int unsigned max1(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/acc_add_sat.sv
// acc_add_sat
//   Combinational W-bit unsigned adder with carry-out reported as ovf.
//   Build option ADDER_ACC_SATURATE_EN: when defined, an overflowing sum
//   clamps to all-ones; otherwise it wraps modulo 2^W.
// Ports:
//   a, b : addends (W bits, unsigned)
//   sum  : result (wrapped or clamped)
//   ovf  : carry out of bit W-1
module acc_add_sat #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[W];
`ifdef ADDER_ACC_SATURATE_EN
    // Once clamped, further non-zero adds keep overflowing and re-clamp,
    // so the total stays pinned at all-ones for the rest of the burst.
    sum  = ovf ? '1 : full[W-1:0];
`else
    sum  = full[W-1:0];
`endif
  end

endmodule

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
//   Sums programmable-length bursts of adder results and presents each
//   burst total on a valid/ready output with a sticky overflow flag.
//   Results arriving while a total is stalled are dropped and counted.
//   Build option ADDER_ACC_SATURATE_EN selects a clamping accumulator
//   (see acc_add_sat); default is wrap-around.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid, in_data   : adder result stream (no back-pressure)
//   burst_len           : beats per burst, sampled on the first beat (0 -> 1)
//   out_valid/out_ready : burst total handshake
//   out_sum, out_count  : burst total and beat count (0 while !out_valid)
//   out_ovf             : a carry out of ACC_W occurred during the burst
//   drop_cnt            : saturating count of dropped results
//   busy                : FSM not in IDLE
// ACC_W must be >= IN_W.
module adder_result_accumulator
  import adder_acc_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_data,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;
  logic               ovf;
  logic               valid_q;

  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [CNT_W-1:0]   start_len;
  logic [CNT_W-1:0]   cnt_next;
  logic               handshake;
  logic               start;

  acc_add_sat #(.W(ACC_W)) u_add (
    .a   (acc),
    .b   (ACC_W'(in_data)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign start_len = CNT_W'(max1(32'(burst_len)));
  assign cnt_next  = cnt + CNT_W'(1);
  assign handshake = valid_q & out_ready;
  // A beat starts a new burst from IDLE, or in HOLD when the total is
  // accepted in the same cycle (no bubble between bursts).
  assign start     = in_valid & ((state == IDLE) | ((state == HOLD) & handshake));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      ovf      <= 1'b0;
      valid_q  <= 1'b0;
      drop_cnt <= '0;
    end else if (start) begin
      acc     <= ACC_W'(in_data);
      cnt     <= CNT_W'(1);
      len_q   <= start_len;
      ovf     <= 1'b0;
      state   <= (start_len == CNT_W'(1)) ? HOLD : ACCUM;
      valid_q <= (start_len == CNT_W'(1));
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= add_sum;
            ovf <= ovf | add_ovf;
            cnt <= cnt_next;
            if (cnt_next == len_q) begin
              state   <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end else if (in_valid && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
          end
        end
        IDLE:    ;
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = valid_q ? acc : '0;
  assign out_count = valid_q ? cnt : '0;
  assign out_ovf   = valid_q & ovf;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_result_accumulator.sv
// tb_adder_result_accumulator
//   Directed and random stimulus against a transaction-level model: beats
//   are collected per burst, each completed burst is summarised with plain
//   arithmetic into an expected total, and a monitor compares the DUT
//   output on every cycle. ACC_W is set to 10 so eight 255s overflow.
module tb_adder_result_accumulator;

  localparam int IN_W    = 8;
  localparam int CNT_W   = 4;
  localparam int ACC_W   = 10;
  localparam int DROP_W  = 8;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic [CNT_W-1:0]  burst_len;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;
  logic [DROP_W-1:0] drop_cnt;
  logic              busy;

  adder_result_accumulator #(
    .IN_W(IN_W), .CNT_W(CNT_W), .ACC_W(ACC_W), .DROP_W(DROP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .burst_len (burst_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int sum;
    int count;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   m_beats[$];
  int   m_len;
  bit   m_pending;
  int   m_drops;

  function automatic exp_t summarize(input int beats[$]);
    exp_t e;
    int total = 0;
    foreach (beats[i]) total += beats[i];
    e.count = beats.size();
    e.ovf   = (total > ACC_MAX) ? 1 : 0;
`ifdef ADDER_ACC_SATURATE_EN
    e.sum   = (total > ACC_MAX) ? ACC_MAX : total;
`else
    e.sum   = total % (ACC_MAX + 1);
`endif
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_beats.delete();
      exp_q.delete();
      m_pending = 1'b0;
      m_drops   = 0;
      m_len     = 1;
    end else begin
      if (m_pending && out_ready) m_pending = 1'b0;
      if (in_valid) begin
        if (m_pending) begin
          if (m_drops < DROP_MAX) m_drops++;
        end else begin
          if (m_beats.size() == 0) m_len = (burst_len == 0) ? 1 : int'(burst_len);
          m_beats.push_back(int'(in_data));
          if (m_beats.size() == m_len) begin
            exp_q.push_back(summarize(m_beats));
            m_beats.delete();
            m_pending = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      check("out_valid", int'(out_valid), int'(m_pending));
      check("busy", int'(busy), (m_pending || m_beats.size() != 0) ? 1 : 0);
      check("drop_cnt", int'(drop_cnt), m_drops);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_total", 1, 0);
        end else begin
          check("out_sum", int'(out_sum), exp_q[0].sum);
          check("out_count", int'(out_count), exp_q[0].count);
          check("out_ovf", int'(out_ovf), exp_q[0].ovf);
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("idle_outputs_zero", int'(out_sum) + int'(out_count) + int'(out_ovf), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic v, input int d, input int l, input logic r);
    in_valid  = v;
    in_data   = IN_W'(d);
    burst_len = CNT_W'(l);
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    burst_len = '0;
    out_ready = 1'b0;
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    check("rst_out_sum", int'(out_sum), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic burst of four.
    for (int i = 1; i <= 4; i++) cycle(1'b1, i, 4, 1'b1);
    cycle(1'b0, 0, 4, 1'b1);
    cycle(1'b0, 0, 4, 1'b1);

    // Zero length behaves as one.
    cycle(1'b1, 5, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);

    // Back-pressure with a dropped beat.
    cycle(1'b1, 7, 2, 1'b0);
    cycle(1'b1, 8, 2, 1'b0);
    cycle(1'b1, 9, 2, 1'b0);
    cycle(1'b0, 0, 2, 1'b0);
    cycle(1'b0, 0, 2, 1'b0);
    cycle(1'b0, 0, 2, 1'b1);
    cycle(1'b0, 0, 2, 1'b1);
    check("drop_after_backpressure", int'(drop_cnt), 1);

    // Overflow: eight beats of 255 into a 10-bit accumulator.
    for (int i = 0; i < 8; i++) cycle(1'b1, 255, 8, 1'b1);
    cycle(1'b0, 0, 8, 1'b1);
    cycle(1'b0, 0, 8, 1'b1);

    // Asynchronous reset in the middle of a burst.
    cycle(1'b1, 3, 4, 1'b1);
    cycle(1'b1, 3, 4, 1'b1);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_busy", int'(busy), 0);
    check("async_drop_cnt", int'(drop_cnt), 0);
    #7;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1, 4, 1'b1);
    cycle(1'b0, 0, 4, 1'b1);
    cycle(1'b0, 0, 4, 1'b1);

    // Back-to-back single-beat bursts.
    for (int i = 1; i <= 3; i++) cycle(1'b1, i, 1, 1'b1);
    cycle(1'b0, 0, 1, 1'b1);
    cycle(1'b0, 0, 1, 1'b1);
    check("b2b_drop_cnt", int'(drop_cnt), 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                        : int'($urandom_range(0, 4)),
            ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
    end

    // Drain any held total, bounded.
    for (int i = 0; i < 60 && (exp_q.size() != 0 || m_pending); i++)
      cycle(1'b0, 0, 0, 1'b1);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_result_accumulator.md
Name: adder_result_accumulator

Overview:
- Downstream stage of the adder. Consumes the adder's result stream (one beat per in_valid).
- Sums programmable-length bursts of results and presents each burst total on a valid/ready output with an overflow flag.
- Results that arrive while a total is stalled are dropped and counted.
- Feeds the scoreboard-facing checker and any later reduction logic.

Parameters:
- IN_W, 8, width of the adder result word (in_data).
- CNT_W, 4, width of burst_len and out_count; maximum burst is 2^CNT_W-1.
- ACC_W, 12, accumulator and out_sum width; must be >= IN_W.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- in_valid  input  1  adder result valid this cycle; no back-pressure to the adder.
- in_data  input  IN_W  adder result (unsigned).
- burst_len  input  CNT_W  beats per burst; sampled on the first beat of a burst; 0 treated as 1.
- out_valid  output  1  burst total available.
- out_ready  input  1  consumer accepts the total.
- out_sum  output  ACC_W  burst total.
- out_count  output  CNT_W  beats in the total.
- out_ovf  output  1  accumulation exceeded ACC_W during this burst.
- drop_cnt  output  DROP_W  results dropped since reset; saturates at all-ones.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE; acc, cnt, len_q, out_ovf, drop_cnt = 0; out_valid=0; busy=0.
- IDLE:
  - in_valid: acc=in_data; cnt=1; len_q=max(burst_len,1); ovf cleared.
  - Next state is HOLD if len_q==1, else ACCUM.
- ACCUM:
  - in_valid: acc=acc+in_data; cnt++.
  - cnt reaching len_q -> HOLD.
  - in_valid=0 -> hold all state; gaps between beats are allowed.
- HOLD:
  - out_valid=1; out_sum=acc; out_count=cnt; out_ovf=ovf; all stable until the handshake.
  - Handshake = out_valid & out_ready.
  - Handshake with in_valid in the same cycle: that beat starts a new burst (IDLE rules, burst_len resampled). No bubble.
  - Handshake without in_valid -> IDLE.
  - in_valid without handshake -> beat dropped; drop_cnt++ (saturating).
- Latency: out_valid asserts on the cycle after the last beat of a burst is accepted.
- Arithmetic: unsigned, in_data zero-extended to ACC_W.
  - Any carry out of ACC_W sets ovf, which stays sticky until the next burst starts.
  - Default result: wrap modulo 2^ACC_W.
- burst_len changes mid-burst have no effect; only len_q is used.
- out_sum, out_count and out_ovf read 0 when out_valid=0.

Optional Feature:
- Macro: ADDER_ACC_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^ACC_W-1 and stays there for the rest of the burst; ovf is still set.
- Undefined: acc wraps modulo 2^ACC_W; ovf is set.

Decomposition:
- Package adder_acc_pkg:
  - state enum {IDLE, ACCUM, HOLD} (2 bits).
  - Default width constants.
  - Function max1(len) mapping 0 to 1.
- Sub-module acc_add_sat: combinational a+b with overflow output; wrap/saturate selected by ADDER_ACC_SATURATE_EN.
- FSM, counters and output register stay in the top module.

Test Plan:
- Basic burst: burst_len=4; in_data 1,2,3,4 on consecutive cycles; out_ready=1 -> one cycle later out_valid=1, out_sum=10, out_count=4, out_ovf=0, then IDLE.
- Zero length: burst_len=0; single beat 5 -> out_sum=5, out_count=1 on the next cycle.
- Back-pressure and drop: burst_len=2; beats 7,8; out_ready=0 for 3 cycles; beat 9 arrives during HOLD -> out_sum=15 stays stable, drop_cnt=1; the handshake occurs on the first cycle out_ready=1 -> IDLE.
- Overflow (ACC_W=10): burst_len=8, eight beats of 255.
  - Without the macro: out_sum=1016, out_ovf=1.
  - With ADDER_ACC_SATURATE_EN: out_sum=1023, out_ovf=1.
- Async reset mid-burst: burst_len=4; beats 3,3; then reset=0 for one cycle (mid-cycle) -> out_valid, busy and drop_cnt drop to 0 immediately. Next burst of four 1s -> out_sum=4.
- Back-to-back: burst_len=1; out_ready=1; in_valid held high with 1,2,3 -> out_sum 1,2,3 on consecutive cycles, drop_cnt=0.
